// File: rtl/dram_line_responder_pkg.sv
// Shared definitions for the DRAM line responder: FSM state encodings that
// sit beside the cache controller state codes.
package dram_line_responder_pkg;

   // 3-bit DRAM responder states
   typedef enum logic [2:0] {
      DRAM_STATE_IDLE    = 3'd0,
      DRAM_STATE_BUSY    = 3'd1,
      DRAM_STATE_ACK     = 3'd2,
      DRAM_STATE_RELEASE = 3'd3,
      DRAM_STATE_REFRESH = 3'd4
   } dram_state_e;

endpackage

// File: rtl/dram_line_array.sv
// Line storage for the DRAM responder: DEPTH x LINE_W, one synchronous port.
// The read is registered every cycle at the current index (read-first on a
// same-cycle write). Contents are never cleared.
module dram_line_array #(
   parameter int LINE_W = 256,
   parameter int DEPTH  = 1024
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] idx,
   input  logic [LINE_W-1:0]        wdata,
   output logic [LINE_W-1:0]        rdata
);

   logic [LINE_W-1:0] mem [DEPTH];

   // single port: optional write, registered read of the same index
   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= wdata;
      end
      rdata <= mem[idx];
   end

endmodule

// File: rtl/dram_line_responder.sv
// Main-memory end of the L1 <-> DRAM line interface. Captures a fill or
// writeback request, waits LATENCY cycles, then acks for one cycle. A held
// dram_cs is parked in RELEASE so it is serviced only once.
// Optional feature: define DRAM_REFRESH_EN to add periodic refresh cycles.
module dram_line_responder
   import dram_line_responder_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int LINE_W      = 256,
   parameter int DEPTH       = 1024,
   parameter int LATENCY     = 10,
   parameter int REFRESH_INT = 500,
   parameter int REFRESH_LEN = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dram_cs,
   input  logic              dram_we,
   input  logic [ADDR_W-1:0] dram_addr,
   input  logic [LINE_W-1:0] dram_wdata,
   output logic [LINE_W-1:0] dram_rdata,
   output logic              dram_ack,
   output logic              dram_busy
);

   localparam int OFF_W = $clog2(LINE_W / 8);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(LATENCY + 1);

   dram_state_e       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic              capture;
   logic              we_q;
   logic [IDX_W-1:0]  idx_q;
   logic [LINE_W-1:0] wdata_q;
   logic [LINE_W-1:0] arr_rdata;
   logic [LINE_W-1:0] rdata_hold_q;
   logic              refresh_due;
   logic              refresh_done;

   // Offset and aliasing bits of the address are deliberately dropped
   logic unused_addr_bits;
   assign unused_addr_bits = ^{dram_addr[ADDR_W-1:OFF_W+IDX_W], dram_addr[OFF_W-1:0]};

`ifdef DRAM_REFRESH_EN
   localparam int RI_W = $clog2(REFRESH_INT + 1);
   localparam int RL_W = $clog2(REFRESH_LEN + 1);

   logic [RI_W-1:0] ref_tick_q;
   logic [RL_W-1:0] ref_len_q;
   logic            ref_pend_q;

   assign refresh_due  = ref_pend_q;
   assign refresh_done = (ref_len_q == '0);

   // free-running refresh timer; overdue refreshes collapse into one pending flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ref_tick_q <= '0;
         ref_len_q  <= '0;
         ref_pend_q <= 1'b0;
      end else begin
         if (ref_tick_q == RI_W'(REFRESH_INT - 1)) begin
            ref_tick_q <= '0;
            ref_pend_q <= 1'b1;
         end else begin
            ref_tick_q <= ref_tick_q + 1'b1;
            if (state_q == DRAM_STATE_REFRESH && refresh_done) begin
               ref_pend_q <= 1'b0;
            end
         end
         if (state_q == DRAM_STATE_IDLE && ref_pend_q) begin
            ref_len_q <= RL_W'(REFRESH_LEN - 1);
         end else if (state_q == DRAM_STATE_REFRESH && !refresh_done) begin
            ref_len_q <= ref_len_q - 1'b1;
         end
      end
   end
`else
   logic unused_refresh_cfg;
   assign unused_refresh_cfg = (REFRESH_INT > 0) ^ (REFRESH_LEN > 0);
   assign refresh_due  = 1'b0;
   assign refresh_done = 1'b1;
`endif

   // state register and latency counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= DRAM_STATE_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (capture) begin
            cnt_q <= CNT_W'(LATENCY - 1);
         end else if (state_q == DRAM_STATE_BUSY && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

   // next state and handshake outputs
   always_comb begin
      state_d   = state_q;
      capture   = 1'b0;
      dram_ack  = 1'b0;
      dram_busy = (state_q != DRAM_STATE_IDLE);
      case (state_q)
         DRAM_STATE_IDLE: begin
            if (refresh_due) begin
               state_d = DRAM_STATE_REFRESH;
            end else if (dram_cs) begin
               state_d = DRAM_STATE_BUSY;
               capture = 1'b1;
            end
         end
         DRAM_STATE_BUSY: begin
            if (cnt_q == '0) begin
               state_d = DRAM_STATE_ACK;
            end
         end
         DRAM_STATE_ACK: begin
            dram_ack = 1'b1;
            state_d  = dram_cs ? DRAM_STATE_RELEASE : DRAM_STATE_IDLE;
         end
         DRAM_STATE_RELEASE: begin
            if (!dram_cs) begin
               state_d = DRAM_STATE_IDLE;
            end
         end
         DRAM_STATE_REFRESH: begin
            // a request waiting behind the refresh is picked up on the exit
            // edge, as if passing through IDLE in zero time
            if (refresh_done) begin
               if (dram_cs) begin
                  state_d = DRAM_STATE_BUSY;
                  capture = 1'b1;
               end else begin
                  state_d = DRAM_STATE_IDLE;
               end
            end
         end
         default: state_d = DRAM_STATE_IDLE;
      endcase
   end

   // request capture; inputs are not looked at again until the next request
   always_ff @(posedge clk) begin
      if (capture) begin
         we_q    <= dram_we;
         idx_q   <= dram_addr[OFF_W +: IDX_W];
         wdata_q <= dram_wdata;
      end
   end

   dram_line_array #(
      .LINE_W (LINE_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk   (clk),
      .we    ((state_q == DRAM_STATE_ACK) && we_q),
      .idx   (idx_q),
      .wdata (wdata_q),
      .rdata (arr_rdata)
   );

   // holds the last read line so write acks leave dram_rdata untouched
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata_hold_q <= '0;
      end else if (state_q == DRAM_STATE_ACK && !we_q) begin
         rdata_hold_q <= arr_rdata;
      end
   end

   // array read launched on the BUSY->ACK edge is visible during the ack cycle
   assign dram_rdata = (state_q == DRAM_STATE_ACK && !we_q) ? arr_rdata : rdata_hold_q;

endmodule

// File: tb/tb_dram_line_responder.sv
// Directed bench for dram_line_responder (default build, refresh disabled).
module tb_dram_line_responder;

   localparam int ADDR_W  = 32;
   localparam int LINE_W  = 256;
   localparam int LATENCY = 10;

   logic              clk = 1'b0;
   logic              rst;
   logic              dram_cs;
   logic              dram_we;
   logic [ADDR_W-1:0] dram_addr;
   logic [LINE_W-1:0] dram_wdata;
   logic [LINE_W-1:0] dram_rdata;
   logic              dram_ack;
   logic              dram_busy;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   dram_line_responder #(
      .ADDR_W  (ADDR_W),
      .LINE_W  (LINE_W),
      .DEPTH   (1024),
      .LATENCY (LATENCY)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .dram_cs    (dram_cs),
      .dram_we    (dram_we),
      .dram_addr  (dram_addr),
      .dram_wdata (dram_wdata),
      .dram_rdata (dram_rdata),
      .dram_ack   (dram_ack),
      .dram_busy  (dram_busy)
   );

   typedef struct {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [LINE_W-1:0] wdata;
      bit                chk_rd;
      logic [LINE_W-1:0] exp_rd;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // issue one request; lat = cycles from capturing edge to ack (-1 on timeout)
   task automatic run_req(input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [LINE_W-1:0] wd, input bit hold, input int drop_at,
                          output int lat, output bit busy_ok);
      @(negedge clk);
      dram_cs    = 1'b1;
      dram_we    = we;
      dram_addr  = addr;
      dram_wdata = wd;
      lat        = -1;
      busy_ok    = 1'b1;
      for (int k = 1; k <= LATENCY + 20; k++) begin
         @(posedge clk);
         #1;
         if (!dram_busy) busy_ok = 1'b0;
         if (dram_ack) begin
            lat = k - 1;
            break;
         end
         if (k == drop_at) dram_cs = 1'b0;
      end
      if (!hold) begin
         @(negedge clk);
         dram_cs = 1'b0;
      end
   endtask

   initial begin
      int   lat;
      bit   bok;
      int   acks;
      bit   busy_hold;
      logic [LINE_W-1:0] a5, p5a, pf0, pbad, pc3, one;

      a5   = {32{8'hA5}};
      p5a  = {32{8'h5A}};
      pf0  = {32{8'h0F}};
      pbad = {32{8'hBD}};
      pc3  = {32{8'hC3}};
      one  = 256'h1;

      vecs[0] = '{1'b0, 32'h0000_0040, '0,   1'b0, '0};
      vecs[1] = '{1'b1, 32'h0000_0040, p5a,  1'b0, '0};
      vecs[2] = '{1'b0, 32'h0000_0040, '0,   1'b1, p5a};
      vecs[3] = '{1'b1, 32'h0000_1000, a5,   1'b1, p5a};
      vecs[4] = '{1'b0, 32'h0000_1000, '0,   1'b1, a5};
      vecs[5] = '{1'b0, 32'h0000_1004, '0,   1'b1, a5};
      vecs[6] = '{1'b1, 32'h0000_0000, one,  1'b1, a5};
      vecs[7] = '{1'b0, 32'h0000_8000, '0,   1'b1, one};
      vecs[8] = '{1'b1, 32'h0000_0200, pf0,  1'b1, one};
      vecs[9] = '{1'b0, 32'h0000_0200, '0,   1'b1, pf0};

      rst        = 1'b0;
      dram_cs    = 1'b0;
      dram_we    = 1'b0;
      dram_addr  = '0;
      dram_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ack",   LINE_W'(dram_ack),  '0);
      chk("reset_busy",  LINE_W'(dram_busy), '0);
      chk("reset_rdata", dram_rdata,         '0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 10; i++) begin
         run_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b0, -1, lat, bok);
         chk($sformatf("v%0d_latency", i), LINE_W'(lat), LINE_W'(LATENCY));
         chk($sformatf("v%0d_busy", i), LINE_W'(bok), LINE_W'(1));
         if (vecs[i].chk_rd) chk($sformatf("v%0d_rdata", i), dram_rdata, vecs[i].exp_rd);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_ack_single", i), LINE_W'(dram_ack), '0);
         chk($sformatf("v%0d_idle", i), LINE_W'(dram_busy), '0);
         if (vecs[i].chk_rd) chk($sformatf("v%0d_rdata_held", i), dram_rdata, vecs[i].exp_rd);
      end

      // cs held high long after the ack: exactly one ack, parked busy
      run_req(1'b0, 32'h0000_1000, '0, 1'b1, -1, lat, bok);
      chk("hold_latency", LINE_W'(lat), LINE_W'(LATENCY));
      acks      = 0;
      busy_hold = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         if (dram_ack) acks++;
         if (!dram_busy) busy_hold = 1'b0;
      end
      chk("hold_extra_acks", LINE_W'(acks), '0);
      chk("hold_busy", LINE_W'(busy_hold), LINE_W'(1));
      @(negedge clk);
      dram_cs = 1'b0;
      @(posedge clk);
      #1;
      chk("hold_release_idle", LINE_W'(dram_busy), '0);
      run_req(1'b0, 32'h0000_0040, '0, 1'b0, -1, lat, bok);
      chk("after_hold_latency", LINE_W'(lat), LINE_W'(LATENCY));
      chk("after_hold_rdata", dram_rdata, p5a);

      // cs dropped during BUSY: request still completes
      run_req(1'b1, 32'h0000_0300, pc3, 1'b0, 3, lat, bok);
      chk("drop_latency", LINE_W'(lat), LINE_W'(LATENCY));
      chk("drop_rdata_unchanged", dram_rdata, p5a);
      run_req(1'b0, 32'h0000_0300, '0, 1'b0, -1, lat, bok);
      chk("drop_readback", dram_rdata, pc3);

      // reset in the middle of a write to 0x200
      @(negedge clk);
      dram_cs    = 1'b1;
      dram_we    = 1'b1;
      dram_addr  = 32'h0000_0200;
      dram_wdata = pbad;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_ack",   LINE_W'(dram_ack),  '0);
      chk("midrst_busy",  LINE_W'(dram_busy), '0);
      chk("midrst_rdata", dram_rdata,         '0);
      dram_cs = 1'b0;
      acks = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (dram_ack) acks++;
      end
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < LATENCY + 4; k++) begin
         @(posedge clk);
         #1;
         if (dram_ack) acks++;
      end
      chk("midrst_no_ack", LINE_W'(acks), '0);
      run_req(1'b0, 32'h0000_0200, '0, 1'b0, -1, lat, bok);
      chk("midrst_latency", LINE_W'(lat), LINE_W'(LATENCY));
      chk("midrst_old_data", dram_rdata, pf0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
